// File: rtl/if_id_queue_pkg.sv
// Shared constants for the IF/ID instruction queue.
package if_id_queue_pkg;
    localparam int InstAddrBus = 32;
    localparam int InstBus     = 32;

    localparam logic Stop         = 1'b1;
    localparam logic NoStop       = 1'b0;
    localparam logic RstActiveLow = 1'b0;

    localparam logic [31:0] ZeroWord = 32'h0000_0000;
endpackage

// File: rtl/inst_queue_mem.sv
// Storage array for the IF/ID queue: one synchronous write port, one asynchronous read port.
module inst_queue_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    // No reset: which entries hold live data is tracked by the owner's pointers and count.
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/if_id_queue.sv
// DEPTH-entry instruction queue between fetch and decode with a registered ID output
// and an empty-queue bypass so an idle pipeline sees single-cycle IF->ID latency.
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int ADDR_W    = InstAddrBus,
    parameter int INST_W    = InstBus,
    parameter int DEPTH     = 4,
    parameter int BYTE_SWAP = 1,
    parameter int STALL_W   = 6,
    parameter int STALL_ID  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [STALL_W-1:0]         stall,
    input  logic                       flush,
    input  logic                       if_valid,
    input  logic [ADDR_W-1:0]          if_pc,
    input  logic [INST_W-1:0]          if_inst,
    output logic                       if_ready,
    output logic                       id_valid,
    output logic [ADDR_W-1:0]          id_pc,
    output logic [INST_W-1:0]          id_inst,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH+1);
    localparam int NBYTES = INST_W / 8;
    localparam int ENT_W  = ADDR_W + INST_W;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [INST_W-1:0] entry_inst;
    logic [ENT_W-1:0]  head;
    logic              advance;
    logic              empty;
    logic              push;
    logic              pop;
    logic              bypass;
    logic              push_to_mem;
    logic              unused_stall;

    generate
        if (BYTE_SWAP != 0) begin : g_swap
            for (genvar k = 0; k < NBYTES; k++) begin : g_lane
                assign entry_inst[8*k +: 8] = if_inst[8*(NBYTES-1-k) +: 8];
            end
        end else begin : g_pass
            assign entry_inst = if_inst;
        end
    endgenerate

    // Handshake: a word transfers on a rising edge where if_valid and if_ready are both 1
    // and flush is 0; if_ready depends only on the registered count, IF holds a word until it transfers.
    assign if_ready     = (count < FULL_CNT);
    assign advance      = (stall[STALL_ID] == NoStop);
    assign empty        = (count == '0);
    assign push         = if_valid & if_ready & ~flush;
    assign pop          = advance & ~empty;
    assign bypass       = advance & empty & push;
    assign push_to_mem  = push & ~bypass;
    assign unused_stall = ^stall;

    inst_queue_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W),
        .AW    (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push_to_mem),
        .waddr (wr_ptr),
        .wdata ({if_pc, entry_inst}),
        .raddr (rd_ptr),
        .rdata (head)
    );

    always_ff @(posedge clk) begin
        if (rst == RstActiveLow || flush == Stop) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            id_valid <= 1'b0;
            id_pc    <= ADDR_W'(ZeroWord);
            id_inst  <= INST_W'(ZeroWord);
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(push_to_mem);
            rd_ptr <= rd_ptr + PTR_W'(pop);
            count  <= count + CNT_W'(push_to_mem) - CNT_W'(pop);
            // A held ID stage keeps its current instruction; queued words wait behind it.
            if (advance) begin
                if (pop) begin
                    id_valid <= 1'b1;
                    id_pc    <= head[ENT_W-1:INST_W];
                    id_inst  <= head[INST_W-1:0];
                end else if (push) begin
                    id_valid <= 1'b1;
                    id_pc    <= if_pc;
                    id_inst  <= entry_inst;
                end else begin
                    id_valid <= 1'b0;
                    id_pc    <= ADDR_W'(ZeroWord);
                    id_inst  <= INST_W'(ZeroWord);
                end
            end
        end
    end
endmodule

// File: tb/tb_if_id_queue.sv
// Scoreboard bench for if_id_queue: drivers push expected {pc, inst} entries, a monitor checks ID order.
module tb_if_id_queue;
    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_ready;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic [2:0]  count;

    logic        if_valid_ns;
    logic [31:0] if_pc_ns;
    logic [31:0] if_inst_ns;
    logic        if_ready_ns;
    logic        id_valid_ns;
    logic [31:0] id_pc_ns;
    logic [31:0] id_inst_ns;
    logic [2:0]  count_ns;

    logic [63:0] exp_q[$];
    int          total = 0;
    int          bad = 0;
    logic        adv_s = 1'b0;

    always #5 clk = ~clk;

    if_id_queue #(.BYTE_SWAP(1)) u_dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .if_ready(if_ready),
        .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst), .count(count)
    );

    if_id_queue #(.BYTE_SWAP(0)) u_dut_ns (
        .clk(clk), .rst(rst), .stall(6'b0), .flush(1'b0),
        .if_valid(if_valid_ns), .if_pc(if_pc_ns), .if_inst(if_inst_ns), .if_ready(if_ready_ns),
        .id_valid(id_valid_ns), .id_pc(id_pc_ns), .id_inst(id_inst_ns), .count(count_ns)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // Monitor: an ID load happens on edges with reset released, no flush and no ID stall.
    always @(posedge clk) adv_s = rst && !flush && !stall[2];

    always @(negedge clk) begin
        chk("count_le_depth", 64'(count <= 3'd4), 64'd1);
        if (!id_valid) begin
            chk("bubble_zero", {id_pc, id_inst}, 64'd0);
        end else if (adv_s) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_id_word", {id_pc, id_inst}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                chk("id_order", {id_pc, id_inst}, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] exp_inst);
        logic rdy;
        int   n;
        n = 0;
        if_valid = 1'b1;
        if_pc    = pc;
        if_inst  = inst;
        do begin
            @(negedge clk);
            rdy = if_ready;
            tick();
            n++;
        end while (!rdy && n < 50);
        if (!rdy) chk("push_timeout", 64'd0, 64'd1);
        else exp_q.push_back({pc, exp_inst});
        if_valid = 1'b0;
    endtask

    initial begin
        logic drv_done;
        int   n;
        rst = 1'b0; stall = '0; flush = 1'b0;
        if_valid = 1'b1; if_pc = 32'h100; if_inst = 32'h1234_5678;
        if_valid_ns = 1'b0; if_pc_ns = '0; if_inst_ns = '0;

        // Reset held with IF presenting a word.
        repeat (2) begin
            @(negedge clk);
            chk("rst_id_valid", 64'(id_valid), 64'd0);
            chk("rst_id", {id_pc, id_inst}, 64'd0);
            chk("rst_count", 64'(count), 64'd0);
            chk("rst_if_ready", 64'(if_ready), 64'd1);
        end
        tick();
        if_valid = 1'b0;
        rst = 1'b1;
        tick();

        push_word(32'h100, 32'h1234_5678, 32'h7856_3412);
        chk("first_latency", {31'd0, id_valid, id_inst}, {31'd0, 1'b1, 32'h7856_3412});
        tick();

        // Stall fill then overflow attempt.
        stall = 6'b000100;
        push_word(32'h0, 32'hA000_0001, 32'h0100_00A0);
        push_word(32'h4, 32'hA000_0002, 32'h0200_00A0);
        push_word(32'h8, 32'hA000_0003, 32'h0300_00A0);
        push_word(32'hC, 32'hA000_0004, 32'h0400_00A0);
        if_valid = 1'b1; if_pc = 32'h10; if_inst = 32'hA000_0005;
        repeat (3) begin
            @(negedge clk);
            chk("full_count", 64'(count), 64'd4);
            chk("full_if_ready", 64'(if_ready), 64'd0);
            tick();
        end
        stall = 6'b0;
        push_word(32'h10, 32'hA000_0005, 32'h0500_00A0);
        repeat (8) tick();

        // Bubbles with other stall bits set.
        stall = 6'b111011;
        repeat (3) begin
            @(negedge clk);
            chk("bubble_valid", 64'(id_valid), 64'd0);
            tick();
        end
        stall = 6'b0;

        // Flush with three queued words and a concurrent push.
        stall = 6'b000100;
        push_word(32'h40, 32'h1122_3344, 32'h4433_2211);
        push_word(32'h44, 32'h5566_7788, 32'h8877_6655);
        push_word(32'h48, 32'h99AA_BBCC, 32'hCCBB_AA99);
        @(negedge clk);
        chk("pre_flush_count", 64'(count), 64'd3);
        tick();
        flush = 1'b1; if_valid = 1'b1; if_pc = 32'h20; if_inst = 32'hDEAD_BEEF;
        tick();
        flush = 1'b0; if_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_id_valid", 64'(id_valid), 64'd0);
        tick();
        stall = 6'b0;
        repeat (4) tick();

        // Wrap with stall toggling every two cycles.
        drv_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++)
                    push_word(32'(i * 4), 32'hC0DE_0000 | 32'(i), bswap(32'hC0DE_0000 | 32'(i)));
                drv_done = 1'b1;
            end
            begin
                for (int c = 0; c < 200 && !drv_done; c++) begin
                    if (c % 2 == 0) stall[2] = ~stall[2];
                    tick();
                end
                stall = 6'b0;
            end
        join

        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);

        // Pass-through build.
        if_valid_ns = 1'b1; if_pc_ns = 32'h200; if_inst_ns = 32'hAABB_CCDD;
        tick();
        if_valid_ns = 1'b0;
        chk("noswap_valid", 64'(id_valid_ns), 64'd1);
        chk("noswap_word", {id_pc_ns, id_inst_ns}, {32'h200, 32'hAABB_CCDD});
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
